// File: rtl/filter_lbuf_ctrl_5x5_if.sv
// Handshake/control bundle between the line-buffer controller and the pipeline front end.
// Carries o_err only when FILTER_LBUF_CTRL_ERR_EN is defined.
interface filter_lbuf_ctrl_5x5_if #(
  parameter int unsigned MEM_ADDR_WIDTH = 11,
  parameter int unsigned V_WIDTH        = 11
);
  logic                      i_vsync;
  logic                      i_de;
  logic [MEM_ADDR_WIDTH-1:0] i_hsize;
  logic [V_WIDTH-1:0]        i_vsize;
  logic                      o_mem_ren;
  logic [MEM_ADDR_WIDTH-1:0] o_mem_raddr;
  logic [MEM_ADDR_WIDTH-1:0] o_mem_waddr;
  logic [1:0]                o_mem_sel;
  logic [3:0]                o_pad_y;
  logic                      o_busy;
  logic                      o_frame_done;
`ifdef FILTER_LBUF_CTRL_ERR_EN
  logic [2:0]                o_err;

  modport master (
    output i_vsync, i_de, i_hsize, i_vsize,
    input  o_mem_ren, o_mem_raddr, o_mem_waddr, o_mem_sel, o_pad_y, o_busy, o_frame_done, o_err
  );
  modport slave (
    input  i_vsync, i_de, i_hsize, i_vsize,
    output o_mem_ren, o_mem_raddr, o_mem_waddr, o_mem_sel, o_pad_y, o_busy, o_frame_done, o_err
  );
`else
  modport master (
    output i_vsync, i_de, i_hsize, i_vsize,
    input  o_mem_ren, o_mem_raddr, o_mem_waddr, o_mem_sel, o_pad_y, o_busy, o_frame_done
  );
  modport slave (
    input  i_vsync, i_de, i_hsize, i_vsize,
    output o_mem_ren, o_mem_raddr, o_mem_waddr, o_mem_sel, o_pad_y, o_busy, o_frame_done
  );
`endif
endinterface

// File: rtl/filter_lbuf_ctrl_5x5.sv
// Line-buffer controller for the 5x5 window aligner: addresses, line select, pad flags, flush.
// Define FILTER_LBUF_CTRL_ERR_EN to add the sticky o_err checker.
module filter_lbuf_ctrl_5x5 #(
  parameter int unsigned MEM_ADDR_WIDTH = 11,
  parameter int unsigned V_WIDTH        = 11,
  parameter int unsigned FLUSH_GAP      = 16
) (
  input logic                   clk,
  input logic                   rstn,
  filter_lbuf_ctrl_5x5_if.slave bus
);
  localparam int unsigned GW = $clog2(FLUSH_GAP);

  typedef enum logic [2:0] {
    StIdle, StFill, StRun, StGap1, StFlush1, StGap2, StFlush2, StDone
  } state_e;

  state_e                    st_q;
  logic [MEM_ADDR_WIDTH-1:0] col_q, waddr_q;
  logic [V_WIDTH-1:0]        ln_q;
  logic [GW-1:0]             gap_q;
  logic [3:0]                pad_q;
  logic                      de_q, fl_end_q, inc_q, busy_q, done_q;

  logic                      in_line, line_end, flush, flush_last;
  logic [V_WIDTH-1:0]        ln_nxt;
  logic [3:0]                pad_nxt;

  assign in_line    = (st_q == StFill) || (st_q == StRun);
  assign line_end   = in_line && de_q && !bus.i_de;
  assign flush      = (st_q == StFlush1) || (st_q == StFlush2);
  assign flush_last = flush && (col_q == bus.i_hsize - MEM_ADDR_WIDTH'(1));
  assign ln_nxt     = ln_q + V_WIDTH'(1);

  always_comb begin
    pad_nxt = 4'b0000;
    if (ln_nxt == V_WIDTH'(2))                      pad_nxt = 4'b0001;
    else if (ln_nxt == V_WIDTH'(3))                 pad_nxt = 4'b0010;
    else if (ln_nxt == bus.i_vsize)                 pad_nxt = 4'b1000;
    else if (ln_nxt == bus.i_vsize + V_WIDTH'(1))   pad_nxt = 4'b0100;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q     <= StIdle;
      col_q    <= '0;
      waddr_q  <= '0;
      ln_q     <= '0;
      gap_q    <= '0;
      pad_q    <= '0;
      de_q     <= 1'b0;
      fl_end_q <= 1'b0;
      inc_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      de_q     <= bus.i_de;
      fl_end_q <= flush_last && (st_q == StFlush1);
      // ln advances two cycles after a line (or flush line) ends
      inc_q    <= line_end || fl_end_q;
      if (inc_q) begin
        ln_q  <= ln_nxt;
        pad_q <= pad_nxt;
      end
      if (bus.i_vsync) begin
        st_q     <= StFill;
        busy_q   <= 1'b1;
        ln_q     <= '0;
        pad_q    <= '0;
        gap_q    <= '0;
        inc_q    <= 1'b0;
        fl_end_q <= 1'b0;
        col_q    <= bus.i_de ? MEM_ADDR_WIDTH'(1) : '0;
        if (bus.i_de) waddr_q <= '0;
      end else begin
        unique case (st_q)
          StIdle: begin
          end
          StFill, StRun: begin
            if (bus.i_de) begin
              waddr_q <= col_q;
              if (col_q != '1) col_q <= col_q + MEM_ADDR_WIDTH'(1);
            end else if (de_q) begin
              col_q <= '0;
              if (st_q == StFill && ln_q == V_WIDTH'(1)) begin
                st_q <= StRun;
              end else if (st_q == StRun && ln_q == bus.i_vsize - V_WIDTH'(1)) begin
                // the falling-edge cycle already counts as the first gap cycle
                st_q  <= StGap1;
                gap_q <= GW'(1);
              end
            end
          end
          StGap1, StGap2: begin
            if (gap_q == GW'(FLUSH_GAP - 1)) begin
              gap_q <= '0;
              st_q  <= (st_q == StGap1) ? StFlush1 : StFlush2;
            end else begin
              gap_q <= gap_q + GW'(1);
            end
          end
          StFlush1, StFlush2: begin
            if (flush_last) begin
              col_q <= '0;
              if (st_q == StFlush1) begin
                st_q <= StGap2;
              end else begin
                st_q   <= StDone;
                busy_q <= 1'b0;
                done_q <= 1'b1;
                ln_q   <= '0;
                pad_q  <= '0;
              end
            end else begin
              col_q <= col_q + MEM_ADDR_WIDTH'(1);
            end
          end
          StDone: st_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.o_mem_ren    = ((st_q == StRun) && bus.i_de && (col_q < bus.i_hsize)) || flush;
  assign bus.o_mem_raddr  = col_q;
  assign bus.o_mem_waddr  = waddr_q;
  assign bus.o_mem_sel    = ln_q[1:0];
  assign bus.o_pad_y      = pad_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_frame_done = done_q;

`ifdef FILTER_LBUF_CTRL_ERR_EN
  logic [2:0] err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= '0;
    end else if (bus.i_vsync) begin
      err_q <= {busy_q, 2'b00};
    end else begin
      if (line_end && col_q != bus.i_hsize)     err_q[0] <= 1'b1;
      if (bus.i_de && st_q == StGap1)           err_q[1] <= 1'b1;
    end
  end

  assign bus.o_err = err_q;
`endif
endmodule

// File: tb/tb_filter_lbuf_ctrl_5x5.sv
// Randomised frame-level bench for filter_lbuf_ctrl_5x5 with a timeline reference model.
module tb_filter_lbuf_ctrl_5x5;
  localparam int AW = 11;
  localparam int VW = 11;
  localparam int G  = 16;
  localparam int N  = 4096;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  filter_lbuf_ctrl_5x5_if #(.MEM_ADDR_WIDTH(AW), .V_WIDTH(VW)) bus ();

  filter_lbuf_ctrl_5x5 #(.MEM_ADDR_WIDTH(AW), .V_WIDTH(VW), .FLUSH_GAP(G)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  // Per-cycle stimulus and expected outputs
  bit in_vsync[N];
  bit in_de[N];
  int in_h[N];
  int in_v[N];
  bit e_ren[N];
  int e_raddr[N];
  bit e_wchk[N];
  int e_waddr[N];
  int e_ln[N];
  int e_pad[N];
  bit e_busy[N];
  bit e_done[N];
`ifdef FILTER_LBUF_CTRL_ERR_EN
  int e_err[N];
`endif

  int  n_chk = 0;
  int  n_pass = 0;
  int  cyc = 0;
  int  t9 = -10;
  bit  run_b = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
  endtask

  function automatic int pad_of(input int ln, input int v);
    if (ln == 2)     return 1;
    if (ln == 3)     return 2;
    if (ln == v)     return 8;
    if (ln == v + 1) return 4;
    return 0;
  endfunction

  // Describe one frame starting with vsync at t0; overrides everything after t0.
  task automatic build_frame(input int t0, input int h, input int v, input int blank,
                             input bit same, input int odd, input int odd_len,
                             output int t_end, output int t_f1, output int t_odd);
    int s, len, f, fl1, fl2, l2;
    int base;
    base = e_busy[t0] ? 4 : 0;
    for (int c = t0 + 1; c < N; c++) begin
      in_vsync[c] = 1'b0; in_de[c] = 1'b0; in_h[c] = h; in_v[c] = v;
      e_ren[c] = 1'b0; e_raddr[c] = 0; e_wchk[c] = 1'b0; e_waddr[c] = 0;
      e_ln[c] = 0; e_busy[c] = 1'b0; e_done[c] = 1'b0;
`ifdef FILTER_LBUF_CTRL_ERR_EN
      e_err[c] = base;
`endif
    end
    in_vsync[t0] = 1'b1; in_h[t0] = h; in_v[t0] = v;
    s = same ? t0 : t0 + 2;
    t_odd = 0;
    f = s;
    for (int k = 0; k < v; k++) begin
      len = (k == odd) ? odd_len : h;
      for (int j = 0; j < len; j++) begin
        in_de[s + j]       = 1'b1;
        e_ren[s + j]       = (k >= 2) && (j < h);
        e_raddr[s + j]     = j;
        e_wchk[s + j + 1]  = 1'b1;
        e_waddr[s + j + 1] = j;
      end
      f = s + len;
      if (k == odd) t_odd = f - 1;
      for (int c = f + 2; c < N; c++) e_ln[c] = k + 1;
`ifdef FILTER_LBUF_CTRL_ERR_EN
      if (len != h) for (int c = f + 1; c < N; c++) e_err[c] |= 1;
`endif
      s = f + blank;
    end
    fl1 = f + G;
    fl2 = fl1 + h + G;
    l2  = fl2 + h - 1;
    for (int j = 0; j < h; j++) begin
      e_ren[fl1 + j] = 1'b1; e_raddr[fl1 + j] = j;
      e_ren[fl2 + j] = 1'b1; e_raddr[fl2 + j] = j;
    end
    for (int c = fl1 + h + 2; c < N; c++) e_ln[c] = v + 1;
    for (int c = l2 + 1; c < N; c++) e_ln[c] = 0;
    for (int c = t0 + 1; c <= l2; c++) e_busy[c] = 1'b1;
    e_done[l2 + 1] = 1'b1;
    for (int c = t0 + 1; c < N; c++) e_pad[c] = pad_of(e_ln[c], v);
    t_end = l2 + 2;
    t_f1  = fl1;
  endtask

  always @(negedge clk) begin
    if (run_b) begin
      chk("ren", bus.o_mem_ren, e_ren[cyc]);
      if (e_ren[cyc]) chk("raddr", bus.o_mem_raddr, e_raddr[cyc]);
      if (e_wchk[cyc]) chk("waddr", bus.o_mem_waddr, e_waddr[cyc]);
      chk("sel", bus.o_mem_sel, e_ln[cyc] % 4);
      chk("pad", bus.o_pad_y, e_pad[cyc]);
      chk("busy", bus.o_busy, e_busy[cyc]);
      chk("done", bus.o_frame_done, e_done[cyc]);
`ifdef FILTER_LBUF_CTRL_ERR_EN
      chk("err", bus.o_err, e_err[cyc]);
      if (cyc == t9 + 2) chk("lit_err_odd", bus.o_err, 1);
`endif
      // Hand-derived anchors for the first scripted frames
      case (cyc)
        12:  chk("lit_waddr7", bus.o_mem_waddr, 7);
        16:  begin chk("lit_l1_ren", bus.o_mem_ren, 0); chk("lit_l1_sel", bus.o_mem_sel, 1); end
        28:  begin
          chk("lit_l2_ren", bus.o_mem_ren, 1); chk("lit_l2_raddr", bus.o_mem_raddr, 0);
          chk("lit_l2_sel", bus.o_mem_sel, 2); chk("lit_l2_pad", bus.o_pad_y, 1);
        end
        88:  begin
          chk("lit_f1_ren", bus.o_mem_ren, 1); chk("lit_f1_raddr", bus.o_mem_raddr, 0);
          chk("lit_f1_sel", bus.o_mem_sel, 2); chk("lit_f1_pad", bus.o_pad_y, 8);
        end
        95:  chk("lit_f1_last", bus.o_mem_raddr, 7);
        96:  chk("lit_f1_off", bus.o_mem_ren, 0);
        112: begin
          chk("lit_f2_ren", bus.o_mem_ren, 1); chk("lit_f2_sel", bus.o_mem_sel, 3);
          chk("lit_f2_pad", bus.o_pad_y, 4);
        end
        120: begin
          chk("lit_done", bus.o_frame_done, 1); chk("lit_done_busy", bus.o_busy, 0);
          chk("lit_done_pad", bus.o_pad_y, 0);
        end
        121: chk("lit_done_off", bus.o_frame_done, 0);
        186: chk("lit_abort_pre", bus.o_mem_raddr, 1);
        188: begin
          chk("lit_abort_ren", bus.o_mem_ren, 0); chk("lit_abort_sel", bus.o_mem_sel, 0);
          chk("lit_abort_pad", bus.o_pad_y, 0); chk("lit_abort_busy", bus.o_busy, 1);
        end
        default: ;
      endcase
      if (cyc == t9) chk("lit_ninth_ren", bus.o_mem_ren, 0);
    end
  end

  initial begin
    int t_end, t_f1, t_odd, t0, h, v, odd, ncyc;
    bus.i_vsync = 1'b0; bus.i_de = 1'b0; bus.i_hsize = AW'(8); bus.i_vsize = VW'(6);
    rstn = 1'b0;
    for (int c = 0; c < N; c++) begin
      in_h[c] = 8; in_v[c] = 6;
    end

    // Reset asserted in the middle of a RUN line
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1 bus.i_vsync = 1'b1;
    @(posedge clk); #1 bus.i_vsync = 1'b0;
    for (int k = 0; k < 2; k++) begin
      repeat (8) begin @(posedge clk); #1 bus.i_de = 1'b1; end
      repeat (4) begin @(posedge clk); #1 bus.i_de = 1'b0; end
    end
    repeat (4) begin @(posedge clk); #1 bus.i_de = 1'b1; end
    #2;
    chk("pre_rst_ren", bus.o_mem_ren, 1);
    chk("pre_rst_sel", bus.o_mem_sel, 2);
    rstn = 1'b0;
    #1;
    chk("rst_ren", bus.o_mem_ren, 0);
    chk("rst_raddr", bus.o_mem_raddr, 0);
    chk("rst_waddr", bus.o_mem_waddr, 0);
    chk("rst_sel", bus.o_mem_sel, 0);
    chk("rst_pad", bus.o_pad_y, 0);
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_done", bus.o_frame_done, 0);
`ifdef FILTER_LBUF_CTRL_ERR_EN
    chk("rst_err", bus.o_err, 0);
`endif
    @(posedge clk); #1 rstn = 1'b1;
    // de without vsync must leave the block idle
    repeat (3) begin
      @(negedge clk);
      chk("idle_ren", bus.o_mem_ren, 0);
      chk("idle_waddr", bus.o_mem_waddr, 0);
      chk("idle_busy", bus.o_busy, 0);
    end
    @(posedge clk); #1 bus.i_de = 1'b0;
    repeat (3) @(posedge clk);

    // Scripted frames: nominal 8x6, aborted flush, recovery, long line, then random
    build_frame(2, 8, 6, 4, 1'b0, -1, 0, t_end, t_f1, t_odd);
    build_frame(125, 6, 5, 3, 1'b0, -1, 0, t_end, t_f1, t_odd);
    build_frame(t_f1 + 2, 8, 6, 4, 1'b0, -1, 0, t_end, t_f1, t_odd);
    build_frame(t_end + 3, 8, 6, 5, 1'b1, 3, 9, t_end, t_f1, t_odd);
    t9 = t_odd;
    for (int i = 0; i < 5; i++) begin
      t0  = t_end + int'($urandom_range(0, 4));
      h   = int'($urandom_range(5, 12));
      v   = int'($urandom_range(5, 8));
      odd = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, v - 1)) : -1;
      build_frame(t0, h, v, int'($urandom_range(3, 6)), 1'($urandom_range(0, 1)), odd,
                  int'($urandom_range(h - 2, h + 3)), t_end, t_f1, t_odd);
    end
    ncyc = t_end + 10;

    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      cyc = c;
      run_b = 1'b1;
      bus.i_vsync = in_vsync[c];
      bus.i_de    = in_de[c];
      bus.i_hsize = AW'(in_h[c]);
      bus.i_vsize = VW'(in_v[c]);
    end
    @(negedge clk);
    #1 run_b = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
